braille_digits: RTL and testbench

- Converts one BCD digit (0-9) into the 4-dot Braille digit pattern {w,x,y,z}, where w,x,y,z are the four upper dots of the cell.
- Single registered stage with a valid qualifier. Flags and counts non-BCD codes (10-15).
- Sits between a digit source (counter/display formatter) and a tactile-cell driver.

---
 rtl/braille_pkg.sv | 31 +++
 rtl/braille_digits_if.sv | 28 ++
 rtl/braille_digits_lut.sv | 17 +
 rtl/braille_digits.sv | 66 ++++++
 tb/tb_braille_digits.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/braille_pkg.sv
// Braille digit encoding: lookup table and encoder function.
// braille_encode maps a BCD code to {pattern, err}.
package braille_pkg;

  localparam logic [3:0] BRAILLE_INVALID = 4'b0000;

  localparam logic [3:0] BRAILLE_LUT [0:9] = '{
    4'b0111, 4'b1000, 4'b1001, 4'b1100, 4'b1110,
    4'b1010, 4'b1101, 4'b1111, 4'b1011, 4'b0101
  };

  typedef struct packed {
    logic [3:0] pat;
    logic       err;
  } braille_t;

  function automatic braille_t braille_encode(
    input logic [3:0] bcd
  );
    braille_t r;
    if (bcd > 4'd9) begin
      r.pat = BRAILLE_INVALID;
      r.err = 1'b1;
    end else begin
      r.pat = BRAILLE_LUT[bcd];
      r.err = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/braille_digits_if.sv
// Digit-in / Braille-cell-out bundle.
// master: digit source; slave: braille_digits.
interface braille_digits_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 bcd_valid;
  logic [3:0]           bcd;
  logic                 err_clr;
  logic                 w;
  logic                 x;
  logic                 y;
  logic                 z;
  logic                 cell_valid;
  logic                 bcd_err;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output bcd_valid, bcd, err_clr,
    input  w, x, y, z,
    input  cell_valid, bcd_err, err_count
  );

  modport slave (
    input  bcd_valid, bcd, err_clr,
    output w, x, y, z,
    output cell_valid, bcd_err, err_count
  );
endinterface

// File: rtl/braille_digits_lut.sv
// Combinational BCD -> 4-dot Braille pattern.
// Ports: bcd_i in, pat_o pattern, err_o non-BCD flag.
module braille_lut
  import braille_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [3:0] pat_o,
  output logic       err_o
);
  braille_t enc;

  always_comb begin
    enc   = braille_encode(bcd_i);
    pat_o = enc.pat;
    err_o = enc.err;
  end
endmodule

// File: rtl/braille_digits.sv
// Registered BCD -> Braille cell stage with error counter.
// Ports: clk, reset_n, bus (slave: digit in, cell out).
module braille_digits
  import braille_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  braille_digits_if.slave bus
);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  logic [3:0]           lut_pat;
  logic                 lut_err;
  logic [3:0]           pat_q, pat_d;
  logic                 err_q, err_d;
  logic                 cv_q, cv_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
  logic [ERR_CNT_W-1:0] cnt_base;

  braille_lut u_lut (
    .bcd_i (bus.bcd),
    .pat_o (lut_pat),
    .err_o (lut_err)
  );

  always_comb begin
    pat_d = pat_q;
    err_d = err_q;
    cv_d  = bus.bcd_valid;
    if (bus.bcd_valid) begin
      pat_d = lut_pat;
      err_d = lut_err;
    end
    // clear takes priority, then the same-edge
    // invalid sample still counts
    cnt_base = bus.err_clr ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (bus.bcd_valid && lut_err &&
        cnt_base != CNT_MAX)
      cnt_d = cnt_base + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat_q <= '0;
      err_q <= 1'b0;
      cv_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      pat_q <= pat_d;
      err_q <= err_d;
      cv_q  <= cv_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.w          = pat_q[3];
  assign bus.x          = pat_q[2];
  assign bus.y          = pat_q[1];
  assign bus.z          = pat_q[0];
  assign bus.cell_valid = cv_q;
  assign bus.bcd_err    = err_q;
  assign bus.err_count  = cnt_q;
endmodule

// File: tb/tb_braille_digits.sv
// Self-checking bench for braille_digits.
// Runs 8-bit and 2-bit counter instances in lockstep.
module tb_braille_digits;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  braille_digits_if #(.ERR_CNT_W(8)) ifa ();
  braille_digits_if #(.ERR_CNT_W(2)) ifb ();

  braille_digits #(.ERR_CNT_W(8)) dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifa)
  );

  braille_digits #(.ERR_CNT_W(2)) dut2 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifb)
  );

  logic [3:0] tbl [0:9];

  logic [3:0] m_pat;
  logic       m_cv;
  logic       m_err;
  logic [7:0] m_c8;
  logic [1:0] m_c2;

  typedef struct {
    logic       v;
    logic [3:0] bcd;
    logic       clr;
    logic [3:0] pat;
    logic       cv;
    logic       err;
    logic [7:0] c8;
    logic [1:0] c2;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h",
               nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag,
                         logic [3:0] pat,
                         logic cv, logic err,
                         logic [7:0] c8,
                         logic [1:0] c2);
    chk({tag, " pat8"},
        {28'd0, ifa.w, ifa.x, ifa.y, ifa.z},
        {28'd0, pat});
    chk({tag, " pat2"},
        {28'd0, ifb.w, ifb.x, ifb.y, ifb.z},
        {28'd0, pat});
    chk({tag, " cv8"},
        {31'd0, ifa.cell_valid}, {31'd0, cv});
    chk({tag, " cv2"},
        {31'd0, ifb.cell_valid}, {31'd0, cv});
    chk({tag, " err8"},
        {31'd0, ifa.bcd_err}, {31'd0, err});
    chk({tag, " err2"},
        {31'd0, ifb.bcd_err}, {31'd0, err});
    chk({tag, " cnt8"},
        {24'd0, ifa.err_count}, {24'd0, c8});
    chk({tag, " cnt2"},
        {30'd0, ifb.err_count}, {30'd0, c2});
  endtask

  task automatic drive(logic v, logic [3:0] b,
                       logic clr);
    ifa.bcd_valid = v;
    ifa.bcd       = b;
    ifa.err_clr   = clr;
    ifb.bcd_valid = v;
    ifb.bcd       = b;
    ifb.err_clr   = clr;
  endtask

  task automatic model_reset();
    m_pat = 4'd0;
    m_cv  = 1'b0;
    m_err = 1'b0;
    m_c8  = 8'd0;
    m_c2  = 2'd0;
  endtask

  task automatic step(logic v, logic [3:0] b,
                      logic clr);
    drive(v, b, clr);
    @(posedge clk);
    #1;
    m_cv = v;
    if (v) begin
      if (b <= 4'd9) begin
        m_pat = tbl[b];
        m_err = 1'b0;
      end else begin
        m_pat = 4'd0;
        m_err = 1'b1;
      end
    end
    if (clr) begin
      m_c8 = 8'd0;
      m_c2 = 2'd0;
    end
    if (v && b > 4'd9) begin
      if (m_c8 != 8'hFF) m_c8 = m_c8 + 8'd1;
      if (m_c2 != 2'h3)  m_c2 = m_c2 + 2'd1;
    end
  endtask

  function automatic vec_t mk(
    logic v, logic [3:0] b, logic clr,
    logic [3:0] pat, logic cv, logic err,
    logic [7:0] c8, logic [1:0] c2);
    vec_t t;
    t.v = v;   t.bcd = b;  t.clr = clr;
    t.pat = pat; t.cv = cv; t.err = err;
    t.c8 = c8; t.c2 = c2;
    return t;
  endfunction

  initial begin
    tbl[0] = 4'b0111; tbl[1] = 4'b1000;
    tbl[2] = 4'b1001; tbl[3] = 4'b1100;
    tbl[4] = 4'b1110; tbl[5] = 4'b1010;
    tbl[6] = 4'b1101; tbl[7] = 4'b1111;
    tbl[8] = 4'b1011; tbl[9] = 4'b0101;

    // digits 0..9 back to back
    vecs.push_back(mk(1,0,0,4'b0111,1,0,0,0));
    vecs.push_back(mk(1,1,0,4'b1000,1,0,0,0));
    vecs.push_back(mk(1,2,0,4'b1001,1,0,0,0));
    vecs.push_back(mk(1,3,0,4'b1100,1,0,0,0));
    vecs.push_back(mk(1,4,0,4'b1110,1,0,0,0));
    vecs.push_back(mk(1,5,0,4'b1010,1,0,0,0));
    vecs.push_back(mk(1,6,0,4'b1101,1,0,0,0));
    vecs.push_back(mk(1,7,0,4'b1111,1,0,0,0));
    vecs.push_back(mk(1,8,0,4'b1011,1,0,0,0));
    vecs.push_back(mk(1,9,0,4'b0101,1,0,0,0));
    // hold
    vecs.push_back(mk(1,5,0,4'b1010,1,0,0,0));
    vecs.push_back(mk(0,2,0,4'b1010,0,0,0,0));
    vecs.push_back(mk(0,2,0,4'b1010,0,0,0,0));
    vecs.push_back(mk(0,2,0,4'b1010,0,0,0,0));
    // invalid codes
    vecs.push_back(mk(1,10,0,4'b0000,1,1,1,1));
    vecs.push_back(mk(1,12,0,4'b0000,1,1,2,2));
    vecs.push_back(mk(1,15,0,4'b0000,1,1,3,3));
    vecs.push_back(mk(1,3,0,4'b1100,1,0,3,3));
    vecs.push_back(mk(0,13,0,4'b1100,0,0,3,3));
    vecs.push_back(mk(1,11,0,4'b0000,1,1,4,3));
    vecs.push_back(mk(1,14,0,4'b0000,1,1,5,3));
    // clear with invalid on same edge
    vecs.push_back(mk(1,11,1,4'b0000,1,1,1,1));
    vecs.push_back(mk(0,4,1,4'b0000,0,1,0,0));
    vecs.push_back(mk(1,6,1,4'b1101,1,0,0,0));

    model_reset();
    drive(0, 4'd0, 0);
    #1;
    chk_all("reset", 4'd0, 0, 0, 8'd0, 2'd0);
    @(posedge clk);
    #1;
    chk_all("reset_hold", 4'd0, 0, 0, 8'd0, 2'd0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].bcd, vecs[i].clr);
      chk_all($sformatf("vec%0d", i),
              vecs[i].pat, vecs[i].cv,
              vecs[i].err, vecs[i].c8,
              vecs[i].c2);
    end

    // reset asserted mid-stream between edges
    step(1, 4'd11, 0);
    step(1, 4'd7, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("rst_async", 4'd0, 0, 0, 8'd0, 2'd0);
    drive(1, 4'd9, 0);
    @(posedge clk);
    #1;
    chk_all("rst_low", 4'd0, 0, 0, 8'd0, 2'd0);
    reset_n = 1'b1;
    model_reset();
    step(1, 4'd8, 0);
    chk_all("rst_first", 4'b1011, 1, 0, 8'd0, 2'd0);

    for (int i = 0; i < 1000; i++) begin
      step($urandom_range(0, 3) != 0,
           4'($urandom_range(0, 15)),
           $urandom_range(0, 19) == 0);
      chk_all("rand", m_pat, m_cv, m_err,
              m_c8, m_c2);
    end

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule
